// File: rtl/axis_peak_detector_pkg.sv
// Shared record layout, FSM encoding and default widths for the peak detector.
package peak_pkg;
  localparam int EOF_BIT    = 31;
  localparam int IDX_LSB    = 16;
  localparam int VAL_LSB    = 0;
  localparam int FLD_W      = 15;
  localparam int VAL_W      = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_IDX_W  = 15;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [31:0] make_rec(input logic eof, input logic [FLD_W-1:0] fld,
                                           input logic [VAL_W-1:0] val);
    logic [31:0] r;
    r = '0;
    r[EOF_BIT]            = eof;
    r[IDX_LSB +: FLD_W]   = fld;
    r[VAL_LSB +: VAL_W]   = val;
    return r;
  endfunction
endpackage

// File: rtl/axis_peak_detector_axis_out_reg.sv
// One-entry AXI4-Stream output register; accepts a new word whenever the slot is empty or draining.
module axis_out_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end
endmodule

// File: rtl/axis_peak_detector.sv
// Scans a sample frame for local maxima above a runtime threshold and emits
// one record per peak plus an end-of-frame record when the last beat is not a peak.
module axis_peak_detector
  import peak_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] threshold_in,
  input  logic        threshold_valid,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast
);
  state_t             state, state_nx;
  logic signed [31:0] thr_q, prev1, prev2, sample;
  logic [IDX_W-1:0]   idx1, cnt;
  logic               accept, peak, rec_valid;
  logic [31:0]        rec_data;
  logic               unused_bits;

  assign unused_bits = ^s_axis_tdata[31:DATA_W];
  assign sample = {{(32-DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata[DATA_W-1:0]};
  assign accept = s_axis_tvalid && s_axis_tready;

  // prev1 only has both neighbours once the window is full (RUN)
  assign peak = (state == RUN) && (prev1 > thr_q) && (prev1 > prev2) && (prev1 >= sample);

  always_comb begin
    state_nx = state;
    if (accept) begin
      if (s_axis_tlast) state_nx = EMPTY;
      else begin
        case (state)
          EMPTY:   state_nx = ONE;
          default: state_nx = RUN;
        endcase
      end
    end
  end

  assign rec_valid = accept && (peak || s_axis_tlast);
  assign rec_data  = peak ? make_rec(1'b0, FLD_W'(idx1), prev1[VAL_W-1:0])
                          : make_rec(1'b1, FLD_W'(cnt), '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      thr_q <= '0;
      prev1 <= '0;
      prev2 <= '0;
      idx1  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (threshold_valid) thr_q <= threshold_in;
      if (accept) begin
        prev2 <= prev1;
        prev1 <= sample;
        if (s_axis_tlast || state == EMPTY) idx1 <= '0;
        else                                idx1 <= idx1 + IDX_W'(1);
        if (s_axis_tlast)                   cnt <= '0;
        else if (peak && cnt != '1)         cnt <= cnt + IDX_W'(1);
      end
    end
  end

  axis_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rec_valid),
    .in_ready  (s_axis_tready),
    .in_data   (rec_data),
    .in_last   (s_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast)
  );
endmodule

// File: tb/tb_axis_peak_detector.sv
// Directed and randomized frames checked against a frame-level peak model.
module tb_axis_peak_detector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] threshold_in = '0;
  logic        threshold_valid = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;

  logic rdy_fixed = 1'b1, rdy_rand = 1'b1, rand_rdy = 1'b0;
  int total = 0, passed = 0, model_thr = 0;
  int src[$], frm[$], tu[$];
  logic [32:0] got[$], exp_q[$];

  always #5 clk = ~clk;
  assign m_axis_tready = rand_rdy ? rdy_rand : rdy_fixed;

  axis_peak_detector dut (
    .clk             (clk),
    .rst             (rst),
    .threshold_in    (threshold_in),
    .threshold_valid (threshold_valid),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast)
  );

  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(99) < 70);
  end

  // values at the negedge are what the next rising edge transfers
  always @(negedge clk)
    if (!rst && m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_thr(input int v);
    threshold_in = v;
    threshold_valid = 1'b1;
    tick();
    threshold_valid = 1'b0;
    model_thr = v;
  endtask

  task automatic drive_beat(input int v, input bit last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {16'($urandom), 16'(v)};
    s_axis_tlast  = last;
    frm.push_back(v);
    tu.push_back(model_thr);
  endtask

  task automatic finish_beat();
    int t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("beat_accept_timeout", s_axis_tready, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_beat(input int v, input bit last, input int gap);
    for (int g = 0; g < 3 && $urandom_range(99) < gap; g++) tick();
    drive_beat(v, last);
    finish_beat();
  endtask

  // Reference: scan each interior sample with both neighbours, using the threshold in force at the right neighbour.
  task automatic build_expected();
    int n = frm.size();
    int cnt = 0;
    bit last_peak = 0;
    exp_q.delete();
    for (int i = 2; i < n; i++) begin
      if (frm[i-1] > tu[i] && frm[i-1] > frm[i-2] && frm[i-1] >= frm[i]) begin
        exp_q.push_back({(i == n-1), 1'b0, 15'((i-1) % 32768), 16'(frm[i-1])});
        if (cnt < 32767) cnt++;
        if (i == n-1) last_peak = 1;
      end
    end
    if (!last_peak) exp_q.push_back({1'b1, 1'b1, 15'(cnt), 16'h0000});
  endtask

  task automatic check_frame(input string tag);
    int t = 0;
    build_expected();
    while (got.size() < exp_q.size() && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_rec%0d", tag, i), got[i], exp_q[i]);
    frm.delete();
    tu.delete();
    got.delete();
    tick();
  endtask

  task automatic run_frame(input string tag, input int gap, input int mid_at, input int mid_thr);
    for (int i = 0; i < src.size(); i++) begin
      if (i == mid_at) pulse_thr(mid_thr);
      send_beat(src[i], i == src.size() - 1, gap);
    end
    check_frame(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_tlast", m_axis_tlast, 0);
    chk("reset_sready", s_axis_tready, 1);
    rst = 1'b0;
    tick();

    pulse_thr(10);
    src = '{0, 5, 20, 7, 30, 30, 4};
    run_frame("two_peaks", 0, -1, 0);
    src = '{1, 2, 3};
    run_frame("no_peak", 0, -1, 0);
    pulse_thr(-5);
    src = '{-20, -3, -10, -8};
    run_frame("neg_thr", 0, -1, 0);
    pulse_thr(10);
    src = '{0, 50, 3};
    run_frame("peak_on_last", 0, -1, 0);
    run_frame("mid_thr", 0, 2, 100);

    // Backpressure: peak record stalls, next beat must wait with tdata held
    pulse_thr(10);
    rdy_fixed = 1'b0;
    send_beat(0, 0, 0);
    send_beat(20, 0, 0);
    send_beat(5, 0, 0);
    drive_beat(1, 1);
    @(negedge clk);
    chk("bp_tvalid", m_axis_tvalid, 1);
    chk("bp_sready", s_axis_tready, 0);
    chk("bp_tdata", m_axis_tdata, 32'h0001_0014);
    repeat (3) @(negedge clk);
    chk("bp_hold_tdata", m_axis_tdata, 32'h0001_0014);
    chk("bp_hold_sready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    finish_beat();
    check_frame("backpressure");

    // Reset with a stalled record mid-frame
    rdy_fixed = 1'b0;
    send_beat(0, 0, 0);
    send_beat(20, 0, 0);
    send_beat(5, 0, 0);
    @(negedge clk);
    chk("rst_pending", m_axis_tvalid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_tvalid", m_axis_tvalid, 0);
    chk("rst_mid_tdata", m_axis_tdata, 0);
    chk("rst_mid_sready", s_axis_tready, 1);
    frm.delete();
    tu.delete();
    got.delete();
    model_thr = 0;
    rdy_fixed = 1'b1;
    src = '{-3, 2, 1};
    run_frame("post_rst_thr0", 0, -1, 0);
    pulse_thr(10);
    src = '{0, 20, 0};
    run_frame("post_rst", 0, -1, 0);

    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int len = int'($urandom_range(1, 12));
      int w = (f % 2) ? 40 : 5;
      int mid = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
      src.delete();
      for (int i = 0; i < len; i++) src.push_back(int'($urandom_range(2 * w)) - w);
      pulse_thr(int'($urandom_range(w)) - w / 2);
      run_frame($sformatf("rand%0d", f), 30, mid, int'($urandom_range(w)) - w / 2);
    end
    rand_rdy = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axis_peak_detector.md
Name: axis_peak_detector

Overview:
- Stage directly downstream of the threshold-capture controller; consumes its 32-bit threshold and valid pulse.
- Scans an AXI4-Stream sample frame for local maxima above the threshold.
- Emits one record per peak, plus an end-of-frame record, on an AXI4-Stream master toward the result DMA/FIFO.

Parameters:
- DATA_W, 16, signed sample width (2..16); samples are s_axis_tdata[DATA_W-1:0].
- IDX_W, 15, sample-index width within a frame; DATA_W + IDX_W + 1 <= 32.

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- threshold_in  in  32  signed threshold from upstream controller
- threshold_valid  in  1  one-cycle pulse; latch threshold_in
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  sample ready
- s_axis_tdata  in  32  sample, low DATA_W bits used, upper bits ignored
- s_axis_tlast  in  1  last sample of frame
- m_axis_tvalid  out  1  record valid
- m_axis_tready  in  1  record ready
- m_axis_tdata  out  32  record: [31]=eof flag, [30:16]=index/count, [15:0]=value
- m_axis_tlast  out  1  final record of frame

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, threshold register=0, state=EMPTY, index=0, peak count=0.
- s_axis_tready is high out of reset.
- Threshold: on threshold_valid, thr_q <= threshold_in. New value is used for comparisons from the next cycle on, including mid-frame.
- Compare: sign-extend sample to 32 bits, then signed compare against thr_q.
- Beat accepted = s_axis_tvalid && s_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (single output register, no bubble at full throughput).
- Window registers: prev2, prev1 (samples n-2, n-1), plus index of prev1.
- FSM, advancing on accepted beats only:
  - EMPTY: no samples yet; store sample as prev1, idx=0, go to ONE.
  - ONE: shift window, go to RUN.
  - RUN: shift window.
  - Any state with tlast accepted: go to EMPTY; index and peak count clear after the record is produced.
- Peak rule, evaluated when sample n is accepted in RUN: prev1 > thr_q && prev1 > prev2 && prev1 >= sample_n.
  - Plateau reports its first sample only.
  - Frame's first sample is never a peak (no left neighbour); last sample is never a peak (no right neighbour).
- Record on peak: eof=0, index=idx(prev1), value=prev1 (sign-extended/zero-padded to 16 bits). Written to output register the cycle after the accepting edge (latency 1).
- tlast beat, peak detected: the peak record carries m_axis_tlast=1; no separate eof record.
- tlast beat, no peak: emit eof record: eof=1, [30:16]=peak count of frame (saturating at 2^IDX_W-1), value=0, m_axis_tlast=1.
- Single-sample and two-sample frames therefore always produce exactly one eof record.
- Index counter wraps modulo 2^IDX_W for frames longer than 2^IDX_W samples; count saturates.
- Output register holds tdata/tlast stable while tvalid && !tready.
- Reset mid-frame or with a record pending discards the window, record and threshold; returns to reset values next cycle.
- threshold_valid concurrent with a beat: the beat uses the old threshold.

Decomposition:
- Package peak_pkg: record bit-field localparams (EOF_BIT=31, IDX_LSB=16, VAL_LSB=0), state encoding EMPTY/ONE/RUN, default widths.
- Sub-module axis_out_reg: one-entry AXIS output register (data+last, tvalid/tready, ready-out = !valid || ready). Peak logic stays in top.

Test Plan:
- thr=10; frame 0,5,20,7,30,30,4(last), tready=1 -> records {0,2,20} and {0,4,30}; the 4 beat has no peak, so eof {1,count=2,0} with tlast.
- thr=10; frame 1,2,3(last) -> single record eof=1, count=0, tlast=1; 0x80000000 exactly.
- thr=-5 (0xFFFFFFFB); frame -20,-3,-10,-8(last) -> record index=1, value=0xFFFD, then eof count=1 with tlast.
- Backpressure: hold m_axis_tready=0 with a pending peak -> s_axis_tready=0, tdata stable. Release -> record accepted, input resumes with no loss or duplication.
- Frame 0,50,3(last) with thr=10 -> peak record idx=1 value=50 with tlast=1 and no eof record. Threshold pulse to 100 mid-frame before sample 2 of an identical next frame -> eof only.
- Assert rst while a record is stalled -> m_axis_tvalid=0 next cycle. A following frame 0,20,0(last) with thr pulsed to 10 -> idx=1 record with tlast.
